// File: rtl/time_keeper_bcd.sv
// time_keeper_bcd
//   24 h BCD time base (hh:mm:ss) clocked by the 32.768 kHz crystal clock.
//   Every edge of the divided tick clock advances time by one second. The
//   time can be loaded through a valid/ready interface, which runs IDLE ->
//   CHECK -> COMMIT before the new time appears on the outputs.
//   Optional alarm feature: define TIME_ALARM_EN.
// Ports
//   clk_i, rstn_i      crystal clock, asynchronous active-low reset
//   tick_clk_i         divided clock; each edge counts one second
//   set_valid_i/ready  load handshake; set_hh/mm/ss_i are BCD load values
//   set_err_o          pulse in COMMIT when the load was out of range
//   hour_o/min_o/sec_o registered BCD time
//   sec_pulse_o        pulse when the time advanced because of a tick
//   alarm_*            (TIME_ALARM_EN only) alarm compare, enable, ack, flag
module time_keeper_bcd #(
  parameter logic       TICK_RST = 1'b1,
  parameter logic [5:0] RST_HH   = 6'h00,
  parameter logic [6:0] RST_MM   = 7'h00,
  parameter logic [6:0] RST_SS   = 7'h00
) (
  input  logic       clk_i,
  input  logic       rstn_i,
`ifdef TIME_ALARM_EN
  input  logic       alarm_en_i,
  input  logic [5:0] alarm_hh_i,
  input  logic [6:0] alarm_mm_i,
  input  logic       alarm_ack_i,
  output logic       alarm_o,
`endif
  input  logic       tick_clk_i,
  input  logic       set_valid_i,
  output logic       set_ready_o,
  input  logic [5:0] set_hh_i,
  input  logic [6:0] set_mm_i,
  input  logic [6:0] set_ss_i,
  output logic       set_err_o,
  output logic [5:0] hour_o,
  output logic [6:0] min_o,
  output logic [6:0] sec_o,
  output logic       sec_pulse_o
);

  typedef enum logic [1:0] {IDLE, CHECK, COMMIT} state_t;

  state_t     state;
  logic       tick_q;
  logic [5:0] sh_hh;
  logic [6:0] sh_mm;
  logic [6:0] sh_ss;
  logic       load_ok;

  logic       tick_edge;
  logic       do_load;
  logic       shadow_ok;
  logic [5:0] inc_hh;
  logic [6:0] inc_mm;
  logic [6:0] inc_ss;

  function automatic logic [6:0] bcd7_inc(input logic [6:0] v);
    if (v[3:0] == 4'd9) return {v[6:4] + 3'd1, 4'd0};
    return {v[6:4], v[3:0] + 4'd1};
  endfunction

  always_comb begin
    tick_edge = tick_clk_i ^ tick_q;
    do_load   = (state == COMMIT) && load_ok;
    shadow_ok = (sh_ss[3:0] <= 4'd9) && (sh_ss[6:4] <= 3'd5) &&
                (sh_mm[3:0] <= 4'd9) && (sh_mm[6:4] <= 3'd5) &&
                (sh_hh[3:0] <= 4'd9) &&
                ((sh_hh[5:4] < 2'd2) || ((sh_hh[5:4] == 2'd2) && (sh_hh[3:0] <= 4'd3)));

    // All carries resolved in one step so 23:59:59 wraps to 00:00:00 at once.
    inc_ss = (sec_o == 7'h59) ? '0 : bcd7_inc(sec_o);
    inc_mm = min_o;
    inc_hh = hour_o;
    if (sec_o == 7'h59) begin
      inc_mm = (min_o == 7'h59) ? '0 : bcd7_inc(min_o);
      if (min_o == 7'h59) begin
        if (hour_o == 6'h23)
          inc_hh = '0;
        else if (hour_o[3:0] == 4'd9)
          inc_hh = {hour_o[5:4] + 2'd1, 4'd0};
        else
          inc_hh = {hour_o[5:4], hour_o[3:0] + 4'd1};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      tick_q      <= TICK_RST;
      sh_hh       <= '0;
      sh_mm       <= '0;
      sh_ss       <= '0;
      load_ok     <= 1'b0;
      set_ready_o <= 1'b1;
      set_err_o   <= 1'b0;
      hour_o      <= RST_HH;
      min_o       <= RST_MM;
      sec_o       <= RST_SS;
      sec_pulse_o <= 1'b0;
    end else begin
      tick_q      <= tick_clk_i;
      set_err_o   <= 1'b0;
      sec_pulse_o <= 1'b0;

      case (state)
        IDLE: begin
          if (set_valid_i && set_ready_o) begin
            sh_hh       <= set_hh_i;
            sh_mm       <= set_mm_i;
            sh_ss       <= set_ss_i;
            set_ready_o <= 1'b0;
            state       <= CHECK;
          end
        end
        CHECK: begin
          // Verdict registered here so set_err_o is high during COMMIT.
          load_ok   <= shadow_ok;
          set_err_o <= !shadow_ok;
          state     <= COMMIT;
        end
        COMMIT: begin
          set_ready_o <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          set_ready_o <= 1'b1;
          state       <= IDLE;
        end
      endcase

      // A valid load overrides a coincident tick.
      if (do_load) begin
        hour_o <= sh_hh;
        min_o  <= sh_mm;
        sec_o  <= sh_ss;
      end else if (tick_edge) begin
        hour_o      <= inc_hh;
        min_o       <= inc_mm;
        sec_o       <= inc_ss;
        sec_pulse_o <= 1'b1;
      end
    end
  end

`ifdef TIME_ALARM_EN
  logic alarm_hit;

  always_comb begin
    alarm_hit = tick_edge && !do_load && alarm_en_i &&
                (inc_hh == alarm_hh_i) && (inc_mm == alarm_mm_i) && (inc_ss == 7'h00);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      alarm_o <= 1'b0;
    else if (alarm_hit)
      alarm_o <= 1'b1;
    else if (alarm_ack_i || !alarm_en_i)
      alarm_o <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_time_keeper_bcd.sv
// tb_time_keeper_bcd
//   Directed bench for time_keeper_bcd: reset state, tick counting, rollover,
//   load handshake timing, invalid loads, tick/load collisions, reset mid-load,
//   and the alarm when TIME_ALARM_EN is defined.
module tb_time_keeper_bcd;

  logic       clk_i = 1'b0;
  logic       rstn_i = 1'b0;
  logic       tick_clk_i = 1'b1;
  logic       set_valid_i = 1'b0;
  logic       set_ready_o;
  logic [5:0] set_hh_i = '0;
  logic [6:0] set_mm_i = '0;
  logic [6:0] set_ss_i = '0;
  logic       set_err_o;
  logic [5:0] hour_o;
  logic [6:0] min_o;
  logic [6:0] sec_o;
  logic       sec_pulse_o;
`ifdef TIME_ALARM_EN
  logic       alarm_en_i = 1'b0;
  logic [5:0] alarm_hh_i = '0;
  logic [6:0] alarm_mm_i = '0;
  logic       alarm_ack_i = 1'b0;
  logic       alarm_o;
`endif

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned pulses;

  time_keeper_bcd #(
    .TICK_RST(1'b1),
    .RST_HH  (6'h00),
    .RST_MM  (7'h00),
    .RST_SS  (7'h00)
  ) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
`ifdef TIME_ALARM_EN
    .alarm_en_i (alarm_en_i),
    .alarm_hh_i (alarm_hh_i),
    .alarm_mm_i (alarm_mm_i),
    .alarm_ack_i(alarm_ack_i),
    .alarm_o    (alarm_o),
`endif
    .tick_clk_i (tick_clk_i),
    .set_valid_i(set_valid_i),
    .set_ready_o(set_ready_o),
    .set_hh_i   (set_hh_i),
    .set_mm_i   (set_mm_i),
    .set_ss_i   (set_ss_i),
    .set_err_o  (set_err_o),
    .hour_o     (hour_o),
    .min_o      (min_o),
    .sec_o      (sec_o),
    .sec_pulse_o(sec_pulse_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_time(input string tag, input logic [5:0] hh, input logic [6:0] mm,
                          input logic [6:0] ss);
    chk({tag, ".time"}, {9'd0, hour_o, min_o, sec_o}, {9'd0, hh, mm, ss});
  endtask

  // Accept in cycle N; tick_at=1 puts a tick edge in CHECK (N+1), 2 in COMMIT (N+2).
  task automatic load_seq(input string tag, input logic [5:0] hh, input logic [6:0] mm,
                          input logic [6:0] ss, input int tick_at, input logic exp_err,
                          input logic exp_pulse3, input logic [5:0] ehh,
                          input logic [6:0] emm, input logic [6:0] ess);
    chk({tag, ".rdy0"}, 32'(set_ready_o), 32'd1);
    set_valid_i = 1'b1;
    set_hh_i = hh; set_mm_i = mm; set_ss_i = ss;
    cyc();
    // keep valid high with garbage while busy: must be ignored
    set_hh_i = 6'h11; set_mm_i = 7'h22; set_ss_i = 7'h33;
    if (tick_at == 1) tick_clk_i = ~tick_clk_i;
    chk({tag, ".rdy1"}, 32'(set_ready_o), 32'd0);
    cyc();
    if (tick_at == 2) tick_clk_i = ~tick_clk_i;
    set_valid_i = 1'b0;
    chk({tag, ".rdy2"}, 32'(set_ready_o), 32'd0);
    chk({tag, ".err2"}, 32'(set_err_o), 32'(exp_err));
    chk({tag, ".pulse2"}, 32'(sec_pulse_o), 32'(tick_at == 1));
    cyc();
    chk({tag, ".rdy3"}, 32'(set_ready_o), 32'd1);
    chk({tag, ".err3"}, 32'(set_err_o), 32'd0);
    chk({tag, ".pulse3"}, 32'(sec_pulse_o), 32'(exp_pulse3));
    chk_time(tag, ehh, emm, ess);
  endtask

  typedef struct {
    logic [5:0] hh;
    logic [6:0] mm;
    logic [6:0] ss;
  } tvec_t;

  tvec_t bad[4];

  initial begin
    bad[0] = '{6'h24, 7'h00, 7'h00};
    bad[1] = '{6'h00, 7'h00, 7'h5A};
    bad[2] = '{6'h00, 7'h60, 7'h00};
    bad[3] = '{6'h0A, 7'h00, 7'h00};

    // reset state
    repeat (3) cyc();
    chk_time("rst", 6'h00, 7'h00, 7'h00);
    chk("rst.rdy", 32'(set_ready_o), 32'd1);
    chk("rst.err", 32'(set_err_o), 32'd0);
    chk("rst.pulse", 32'(sec_pulse_o), 32'd0);
`ifdef TIME_ALARM_EN
    chk("rst.alarm", 32'(alarm_o), 32'd0);
`endif
    rstn_i = 1'b1;
    cyc();
    cyc();
    chk("idle.pulse", 32'(sec_pulse_o), 32'd0);

    // 60 tick edges, one every 4 cycles
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      tick_clk_i = ~tick_clk_i;
      for (int j = 0; j < 4; j++) begin
        cyc();
        if (sec_pulse_o) pulses++;
        if (i == 9 && j == 0) chk_time("cnt10", 6'h00, 7'h00, 7'h10);
      end
    end
    chk_time("cnt60", 6'h00, 7'h01, 7'h00);
    chk("cnt60.pulses", pulses, 32'd60);

    // load and day rollover
    load_seq("ld235958", 6'h23, 7'h59, 7'h58, 0, 1'b0, 1'b0, 6'h23, 7'h59, 7'h58);
    tick_clk_i = ~tick_clk_i;
    cyc();
    chk_time("roll1", 6'h23, 7'h59, 7'h59);
    chk("roll1.pulse", 32'(sec_pulse_o), 32'd1);
    cyc(); cyc();
    tick_clk_i = ~tick_clk_i;
    cyc();
    chk_time("roll2", 6'h00, 7'h00, 7'h00);
    chk("roll2.pulse", 32'(sec_pulse_o), 32'd1);
    cyc();
    chk("roll2.pulse_off", 32'(sec_pulse_o), 32'd0);

    // out-of-range loads are discarded
    foreach (bad[k])
      load_seq($sformatf("bad%0d", k), bad[k].hh, bad[k].mm, bad[k].ss, 0, 1'b1, 1'b0,
               6'h00, 7'h00, 7'h00);

    // tick in COMMIT of valid load: load wins, tick dropped
    load_seq("ld_tcommit", 6'h12, 7'h00, 7'h00, 2, 1'b0, 1'b0, 6'h12, 7'h00, 7'h00);
    cyc();
    chk_time("ld_tcommit.after", 6'h12, 7'h00, 7'h00);
    chk("ld_tcommit.after_pulse", 32'(sec_pulse_o), 32'd0);

    // tick in CHECK counts normally, then load lands
    load_seq("ld_tcheck", 6'h01, 7'h02, 7'h03, 1, 1'b0, 1'b0, 6'h01, 7'h02, 7'h03);

    // tick in COMMIT of invalid load: tick applied
    load_seq("bad_tcommit", 6'h24, 7'h00, 7'h00, 2, 1'b1, 1'b1, 6'h01, 7'h02, 7'h04);

`ifdef TIME_ALARM_EN
    alarm_en_i = 1'b1; alarm_hh_i = 6'h00; alarm_mm_i = 7'h01;
    load_seq("al_ld", 6'h00, 7'h00, 7'h58, 0, 1'b0, 1'b0, 6'h00, 7'h00, 7'h58);
    tick_clk_i = ~tick_clk_i;
    cyc();
    chk("al.59", 32'(alarm_o), 32'd0);
    cyc();
    tick_clk_i = ~tick_clk_i;
    cyc();
    chk_time("al.00", 6'h00, 7'h01, 7'h00);
    chk("al.hit", 32'(alarm_o), 32'd1);
    cyc();
    chk("al.hold", 32'(alarm_o), 32'd1);
    alarm_ack_i = 1'b1;
    cyc();
    alarm_ack_i = 1'b0;
    chk("al.ack", 32'(alarm_o), 32'd0);
    load_seq("al_ld2", 6'h00, 7'h01, 7'h00, 0, 1'b0, 1'b0, 6'h00, 7'h01, 7'h00);
    chk("al.load_nohit", 32'(alarm_o), 32'd0);
    cyc();
    chk("al.load_nohit2", 32'(alarm_o), 32'd0);
`endif

    // reset during CHECK
    load_seq("ld_000010", 6'h00, 7'h00, 7'h10, 0, 1'b0, 1'b0, 6'h00, 7'h00, 7'h10);
    set_valid_i = 1'b1;
    set_hh_i = 6'h05; set_mm_i = 7'h05; set_ss_i = 7'h05;
    cyc();
    set_valid_i = 1'b0;
    chk("mid.check_rdy", 32'(set_ready_o), 32'd0);
    rstn_i = 1'b0;
    tick_clk_i = 1'b1;
    #1;
    chk_time("mid.rst", 6'h00, 7'h00, 7'h00);
    chk("mid.rst_rdy", 32'(set_ready_o), 32'd1);
    repeat (3) cyc();
    chk("mid.rst_rdy_hold", 32'(set_ready_o), 32'd1);
    chk_time("mid.rst_hold", 6'h00, 7'h00, 7'h00);
    rstn_i = 1'b1;
    repeat (3) cyc();
    chk_time("mid.after", 6'h00, 7'h00, 7'h00);
    chk("mid.after_rdy", 32'(set_ready_o), 32'd1);
    chk("mid.after_err", 32'(set_err_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
